// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: forward-select codes,
// stage field widths and the forward priority helper.
package hazard_fwd_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int TUSE_W = 2;
    localparam int TNEW_W = 2;
    localparam int SEL_W  = 3;

    localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

    typedef enum logic [SEL_W-1:0] {
        ODATA  = 3'b000,
        EDATA  = 3'b001,
        MDATA  = 3'b010,
        WDATA  = 3'b011,
        WWDATA = 3'b100
    } fwd_sel_e;

    // Register $0 is hard-wired, so a zero address never produces a hit.
    function automatic logic addr_hit(input logic [ADDR_W-1:0] src,
                                      input logic [ADDR_W-1:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    function automatic fwd_sel_e fwd_pick(input logic e_rdy, input logic m_rdy,
                                          input logic w_hit, input logic ww_hit);
        fwd_sel_e sel;
        if (e_rdy) begin
            sel = EDATA;
        end else if (m_rdy) begin
            sel = MDATA;
        end else if (w_hit) begin
            sel = WDATA;
        end else if (ww_hit) begin
            sel = WWDATA;
        end else begin
            sel = ODATA;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_md_busy.sv
// MDU busy interlock: counts down the multiply/divide latency once the
// operation has passed through E and stalls any MDU op waiting in D.
module hazard_md_busy
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic e_md,
    input  logic e_md_div,
    input  logic d_md_start,
    input  logic d_md_use,
    output logic md_stall
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] md_cnt_r;

    // Busy counter: reload when an MDU op leaves E, otherwise count down to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_r <= {CNT_W{1'b0}};
        end else if (e_md) begin
            md_cnt_r <= e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt_r != {CNT_W{1'b0}}) begin
            md_cnt_r <= md_cnt_r - CNT_W'(1);
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

    // Interlock term for any MDU instruction sitting in D.
    always_comb begin
        md_stall = 1'b0;
        if ((d_md_start || d_md_use) && (e_md || (md_cnt_r != {CNT_W{1'b0}}))) begin
            md_stall = 1'b1;
        end else begin
            md_stall = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Central hazard/forwarding controller for the 5-stage pipeline.
// Optional macro FWD_WW_EN adds a WW stage address and the WWDATA select for D.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] D_rs_addr,
    input  logic [ADDR_W-1:0] D_rt_addr,
    input  logic [TUSE_W-1:0] D_Tuse_rs,
    input  logic [TUSE_W-1:0] D_Tuse_rt,
    input  logic [ADDR_W-1:0] D_waddr,
    input  logic [TNEW_W-1:0] D_Tnew,
    input  logic              D_md_start,
    input  logic              D_md_is_div,
    input  logic              D_md_use,
    output logic              stall,
    output logic              E_clr,
    output logic [SEL_W-1:0]  s_D_rs_data,
    output logic [SEL_W-1:0]  s_D_rt_data,
    output logic [SEL_W-1:0]  s_E_rs_data,
    output logic [SEL_W-1:0]  s_E_rt_data,
    output logic [SEL_W-1:0]  s_M_rt_data
);

    logic [ADDR_W-1:0] e_waddr_r, e_rs_r, e_rt_r;
    logic [TNEW_W-1:0] e_tnew_r;
    logic              e_md_r, e_md_div_r;
    logic [ADDR_W-1:0] m_waddr_r, m_rt_r;
    logic [TNEW_W-1:0] m_tnew_r;
    logic [ADDR_W-1:0] w_waddr_r;

    logic data_stall_s, md_stall_s, stall_s;
    logic ww_hit_rs_s, ww_hit_rt_s;

    assign stall_s = data_stall_s | md_stall_s;
    assign stall   = stall_s;
    assign E_clr   = stall_s;

    // Shadow pipeline of destination/Tnew; a stall injects an empty E entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_waddr_r  <= 5'd0;
            e_tnew_r   <= 2'd0;
            e_rs_r     <= 5'd0;
            e_rt_r     <= 5'd0;
            e_md_r     <= 1'b0;
            e_md_div_r <= 1'b0;
            m_waddr_r  <= 5'd0;
            m_tnew_r   <= 2'd0;
            m_rt_r     <= 5'd0;
            w_waddr_r  <= 5'd0;
        end else begin
            if (stall_s) begin
                e_waddr_r  <= 5'd0;
                e_tnew_r   <= 2'd0;
                e_rs_r     <= 5'd0;
                e_rt_r     <= 5'd0;
                e_md_r     <= 1'b0;
                e_md_div_r <= 1'b0;
            end else begin
                e_waddr_r  <= D_waddr;
                e_tnew_r   <= D_Tnew;
                e_rs_r     <= D_rs_addr;
                e_rt_r     <= D_rt_addr;
                e_md_r     <= D_md_start;
                e_md_div_r <= D_md_start & D_md_is_div;
            end
            m_waddr_r <= e_waddr_r;
            m_tnew_r  <= (e_tnew_r == 2'd0) ? 2'd0 : (e_tnew_r - 2'd1);
            m_rt_r    <= e_rt_r;
            w_waddr_r <= m_waddr_r;
        end
    end

`ifdef FWD_WW_EN
    logic [ADDR_W-1:0] ww_waddr_r;

    // Extra write-back stage for a register file without write-through.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ww_waddr_r <= 5'd0;
        end else begin
            ww_waddr_r <= w_waddr_r;
        end
    end

    assign ww_hit_rs_s = addr_hit(D_rs_addr, ww_waddr_r);
    assign ww_hit_rt_s = addr_hit(D_rt_addr, ww_waddr_r);
`else
    assign ww_hit_rs_s = 1'b0;
    assign ww_hit_rt_s = 1'b0;
`endif

    // Data stall: a source is needed before its producer in E or M can deliver it.
    always_comb begin
        data_stall_s = 1'b0;
        if ((addr_hit(D_rs_addr, e_waddr_r) && (D_Tuse_rs < e_tnew_r)) ||
            (addr_hit(D_rs_addr, m_waddr_r) && (D_Tuse_rs < m_tnew_r)) ||
            (addr_hit(D_rt_addr, e_waddr_r) && (D_Tuse_rt < e_tnew_r)) ||
            (addr_hit(D_rt_addr, m_waddr_r) && (D_Tuse_rt < m_tnew_r))) begin
            data_stall_s = 1'b1;
        end else begin
            data_stall_s = 1'b0;
        end
    end

    // Forward selects, youngest ready producer wins.
    always_comb begin
        s_D_rs_data = ODATA;
        s_D_rt_data = ODATA;
        s_E_rs_data = ODATA;
        s_E_rt_data = ODATA;
        s_M_rt_data = ODATA;
        s_D_rs_data = fwd_pick(addr_hit(D_rs_addr, e_waddr_r) && (e_tnew_r == 2'd0),
                               addr_hit(D_rs_addr, m_waddr_r) && (m_tnew_r == 2'd0),
                               addr_hit(D_rs_addr, w_waddr_r), ww_hit_rs_s);
        s_D_rt_data = fwd_pick(addr_hit(D_rt_addr, e_waddr_r) && (e_tnew_r == 2'd0),
                               addr_hit(D_rt_addr, m_waddr_r) && (m_tnew_r == 2'd0),
                               addr_hit(D_rt_addr, w_waddr_r), ww_hit_rt_s);
        s_E_rs_data = fwd_pick(1'b0,
                               addr_hit(e_rs_r, m_waddr_r) && (m_tnew_r == 2'd0),
                               addr_hit(e_rs_r, w_waddr_r), 1'b0);
        s_E_rt_data = fwd_pick(1'b0,
                               addr_hit(e_rt_r, m_waddr_r) && (m_tnew_r == 2'd0),
                               addr_hit(e_rt_r, w_waddr_r), 1'b0);
        s_M_rt_data = fwd_pick(1'b0, 1'b0, addr_hit(m_rt_r, w_waddr_r), 1'b0);
    end

    hazard_md_busy #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy (
        .clk        (clk),
        .reset_n    (reset_n),
        .e_md       (e_md_r),
        .e_md_div   (e_md_div_r),
        .d_md_start (D_md_start),
        .d_md_use   (D_md_use),
        .md_stall   (md_stall_s)
    );

endmodule
